// File: rtl/ram_seq_pkg.sv
// Shared types and defaults for the PSRAM request sequencer.
package ram_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_READ      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_GAP       = 3'd4
  } seq_state_t;

  // Default timing, in clk cycles
  localparam int DEF_RD_HOLD = 24;
  localparam int DEF_WR_HOLD = 24;
  localparam int DEF_GAP     = 8;

  // A byte write copies the low byte onto both lanes, so whichever lane
  // ram_addr[0] selects carries the byte. A word passes through unchanged.
  function automatic logic [15:0] lane_dup(input logic byte_en, input logic [15:0] wdata);
    return byte_en ? {wdata[7:0], wdata[7:0]} : wdata;
  endfunction

endpackage

// File: rtl/ram_req_seq_if.sv
// Bus bundle between the requester/PSRAM side and the request sequencer.
// slave  : the sequencer itself.
// master : the environment around it (CPU requester plus PSRAM data return).
interface ram_req_seq_if;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_byte;
  logic [21:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_busy;

  logic        ram_read;
  logic        ram_write;
  logic        ram_byte;
  logic [21:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata, ram_rdata,
    output cpu_rdata, cpu_ack, cpu_busy,
           ram_read, ram_write, ram_byte, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata, ram_rdata,
    input  cpu_rdata, cpu_ack, cpu_busy,
           ram_read, ram_write, ram_byte, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_req_seq_sync2.sv
// Two-flop synchroniser for a slow asynchronous level, reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; meta_q is allowed to go metastable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ram_req_seq.sv
// PSRAM request sequencer: accepts one CPU request at a time, holds
// ram_read/ram_write for a fixed number of cycles, then forces an idle gap
// so the PSRAM controller returns to idle before the next operation.
// Optional build macro: RAM_SEQ_POSTED_WR_EN -- acknowledge writes in the
// cycle after acceptance instead of after the write strobe completes.
module ram_req_seq
  import ram_seq_pkg::*;
#(
  parameter int RD_HOLD = DEF_RD_HOLD,
  parameter int WR_HOLD = DEF_WR_HOLD,
  parameter int GAP     = DEF_GAP
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  ram_req_seq_if.slave   bus
);

`ifdef RAM_SEQ_POSTED_WR_EN
  localparam bit POSTED_WR = 1'b1;
`else
  localparam bit POSTED_WR = 1'b0;
`endif

  // Counter load values: the counter reaches zero in the last cycle of a phase
  localparam logic [7:0] RD_LOAD  = 8'(RD_HOLD - 1);
  localparam logic [7:0] WR_LOAD  = 8'(WR_HOLD - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

  logic        init_s;

  seq_state_t  state_q,     state_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_ack_q,   cpu_ack_d;
  logic        cpu_busy_q,  cpu_busy_d;
  logic        ram_read_q,  ram_read_d;
  logic        ram_write_q, ram_write_d;
  logic        ram_byte_q,  ram_byte_d;
  logic [21:0] ram_addr_q,  ram_addr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;

  sync2 u_init_sync (
    .clk (clk),
    .rst (rst),
    .d   (init),
    .q   (init_s)
  );

  // Next-state and next-output logic; every output comes straight from a flop
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    cpu_busy_d  = cpu_busy_q;
    ram_read_d  = ram_read_q;
    ram_write_d = ram_write_q;
    ram_byte_d  = ram_byte_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      ST_WAIT_INIT: begin
        if (init_s) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (!init_s) begin
          state_d = ST_WAIT_INIT;
        end else if (bus.cpu_req) begin
          ram_addr_d  = bus.cpu_addr;
          ram_byte_d  = bus.cpu_byte;
          ram_wdata_d = lane_dup(bus.cpu_byte, bus.cpu_wdata);
          cpu_busy_d  = 1'b1;
          if (bus.cpu_we) begin
            state_d     = ST_WRITE;
            ram_write_d = 1'b1;
            cnt_d       = WR_LOAD;
            cpu_ack_d   = POSTED_WR;
          end else begin
            state_d    = ST_READ;
            ram_read_d = 1'b1;
            cnt_d      = RD_LOAD;
          end
        end
      end

      ST_READ: begin
        if (cnt_q == 8'd0) begin
          ram_read_d  = 1'b0;
          cpu_rdata_d = bus.ram_rdata;
          cpu_ack_d   = 1'b1;
          state_d     = ST_GAP;
          cnt_d       = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_WRITE: begin
        if (cnt_q == 8'd0) begin
          ram_write_d = 1'b0;
          cpu_ack_d   = !POSTED_WR;
          state_d     = ST_GAP;
          cnt_d       = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          cpu_busy_d = 1'b0;
          state_d    = init_s ? ST_IDLE : ST_WAIT_INIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d     = ST_WAIT_INIT;
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        cpu_busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset drops the strobes immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WAIT_INIT;
      cnt_q       <= 8'd0;
      cpu_rdata_q <= 16'd0;
      cpu_ack_q   <= 1'b0;
      cpu_busy_q  <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_byte_q  <= 1'b0;
      ram_addr_q  <= 22'd0;
      ram_wdata_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_busy_q  <= cpu_busy_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_byte_q  <= ram_byte_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_busy  = cpu_busy_q;
  assign bus.ram_read  = ram_read_q;
  assign bus.ram_write = ram_write_q;
  assign bus.ram_byte  = ram_byte_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_req_seq.sv
// Bench for ram_req_seq: table vectors, randomized operations against a
// timeline model, and hand-written init / back-to-back / reset sequences.
module tb_ram_req_seq;
  import ram_seq_pkg::*;

  localparam int RD_HOLD = 4;
  localparam int WR_HOLD = 4;
  localparam int GAP     = 2;

`ifdef RAM_SEQ_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic init = 1'b0;

  ram_req_seq_if bus ();

  ram_req_seq #(
    .RD_HOLD (RD_HOLD),
    .WR_HOLD (WR_HOLD),
    .GAP     (GAP)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .init (init),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          checks      = 0;
  int          failures    = 0;
  int          cyc         = 0;
  logic [15:0] model_rdata = 16'h0000;

  typedef struct {
    logic        we;
    logic        byt;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;          // word the PSRAM returns (reads)
    logic [15:0] exp_ram_wdata;  // checked on writes only
    logic [15:0] exp_cpu_rdata;  // checked on reads only
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [15:0] expect_wdata(input logic byt, input logic [15:0] w);
    logic [15:0] r;
    r = w;
    if (byt) r = {w[7:0], w[7:0]};
    return r;
  endfunction

  // Issue one operation from an IDLE cycle N and check cycles N+1 .. N+H+GAP+1
  // against the expected timeline. With hold_req the request stays high so the
  // DUT is expected to accept again in the final (IDLE) cycle.
  task automatic run_op(input logic we, input logic byt, input logic [21:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdata,
                        input logic [15:0] exp_wdata, input logic [15:0] exp_rdata,
                        input bit hold_req);
    int          hold;
    int          ack_k;
    int          last;
    logic [15:0] junk;
    logic [15:0] exp_rd;
    hold  = we ? WR_HOLD : RD_HOLD;
    ack_k = (we && POSTED) ? 1 : hold + 1;
    last  = hold + GAP + 1;
    junk  = rdata ^ 16'($urandom_range(1, 65535));
    $display("op cyc=%0d we=%0b byte=%0b addr=%06h wdata=%04h rdata=%04h hold_req=%0b",
             cyc, we, byt, addr, wdata, rdata, hold_req);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_byte  = byt;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.ram_rdata = junk;
    for (int k = 1; k <= last; k++) begin
      tick;
      exp_rd = (!we && k > hold) ? exp_rdata : model_rdata;
      chk("ram_read",  32'(bus.ram_read),  32'(!we && k <= hold));
      chk("ram_write", 32'(bus.ram_write), 32'(we && k <= hold));
      chk("rw_overlap", 32'(bus.ram_read & bus.ram_write), 32'd0);
      chk("cpu_busy",  32'(bus.cpu_busy),  32'(k <= hold + GAP));
      chk("cpu_ack",   32'(bus.cpu_ack),   32'(k == ack_k));
      chk("ram_addr",  32'(bus.ram_addr),  32'(addr));
      chk("ram_byte",  32'(bus.ram_byte),  32'(byt));
      if (we) chk("ram_wdata", 32'(bus.ram_wdata), 32'(exp_wdata));
      chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_rd));
      if (k < last) begin
        if (!hold_req) bus.cpu_req = 1'b0;
        bus.cpu_we    = 1'($urandom);
        bus.cpu_byte  = 1'($urandom);
        bus.cpu_addr  = 22'($urandom);
        bus.cpu_wdata = 16'($urandom);
      end
      bus.ram_rdata = (k == hold) ? rdata : junk;
    end
    if (!we) model_rdata = exp_rdata;
  endtask

  initial begin
    int          m;
    int          accepted;
    logic        r_we;
    logic        r_byt;
    logic [21:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    bit          r_hold;

    vecs[0] = '{we:1'b0, byt:1'b0, addr:22'h000040, wdata:16'h1111, rdata:16'hA5C3,
                exp_ram_wdata:16'h0000, exp_cpu_rdata:16'hA5C3};
    vecs[1] = '{we:1'b1, byt:1'b1, addr:22'h000101, wdata:16'h0077, rdata:16'h0000,
                exp_ram_wdata:16'h7777, exp_cpu_rdata:16'h0000};
    vecs[2] = '{we:1'b1, byt:1'b0, addr:22'h3FFFFF, wdata:16'hBEEF, rdata:16'h0000,
                exp_ram_wdata:16'hBEEF, exp_cpu_rdata:16'h0000};
    vecs[3] = '{we:1'b0, byt:1'b1, addr:22'h000001, wdata:16'h0000, rdata:16'h1234,
                exp_ram_wdata:16'h0000, exp_cpu_rdata:16'h1234};
    vecs[4] = '{we:1'b1, byt:1'b1, addr:22'h2AAAAA, wdata:16'h12CD, rdata:16'h0000,
                exp_ram_wdata:16'hCDCD, exp_cpu_rdata:16'h0000};
    vecs[5] = '{we:1'b0, byt:1'b0, addr:22'h155555, wdata:16'h0000, rdata:16'hFFFF,
                exp_ram_wdata:16'h0000, exp_cpu_rdata:16'hFFFF};

    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_byte  = 1'b0;
    bus.cpu_addr  = 22'd0;
    bus.cpu_wdata = 16'd0;
    bus.ram_rdata = 16'd0;

    // Reset state
    repeat (3) tick;
    chk("rst_ram_read",  32'(bus.ram_read),  32'd0);
    chk("rst_ram_write", 32'(bus.ram_write), 32'd0);
    chk("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
    chk("rst_cpu_busy",  32'(bus.cpu_busy),  32'd0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_ram_byte",  32'(bus.ram_byte),  32'd0);
    chk("rst_state",     32'(dut.state_q),   32'(ST_WAIT_INIT));

    // Request pending while init is low: nothing may start
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 22'h00ABCD;
    bus.cpu_wdata = 16'h5555;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("noinit_ram_read",  32'(bus.ram_read),  32'd0);
      chk("noinit_ram_write", 32'(bus.ram_write), 32'd0);
      chk("noinit_cpu_busy",  32'(bus.cpu_busy),  32'd0);
    end

    // init rises in cycle m; acceptance must not happen before m+2
    m        = cyc;
    init     = 1'b1;
    accepted = -1;
    for (int i = 0; i < 20 && accepted < 0; i++) begin
      tick;
      if (bus.ram_write) accepted = cyc - 1;
    end
    chk("init_accept_seen", 32'(accepted >= 0), 32'd1);
    if (accepted >= 0) chk("init_accept_early", 32'(accepted >= m + 2), 32'd1);
    $display("init rose cyc=%0d accepted cyc=%0d", m, accepted);
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 40 && bus.cpu_busy; i++) tick;
    chk("init_drain_busy", 32'(bus.cpu_busy), 32'd0);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].we, vecs[i].byt, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
             vecs[i].exp_ram_wdata, vecs[i].exp_cpu_rdata, 1'b0);
    end

    // Request held across the ack: the next op starts in the first IDLE cycle
    run_op(1'b0, 1'b0, 22'h012345, 16'h0000, 16'h3C3C, 16'h0000, 16'h3C3C, 1'b1);
    run_op(1'b1, 1'b0, 22'h054321, 16'h9876, 16'h0000, 16'h9876, 16'h0000, 1'b1);
    run_op(1'b0, 1'b1, 22'h000777, 16'h0000, 16'hC001, 16'h0000, 16'hC001, 1'b0);

    // Randomized operations, sometimes chained with a held request
    for (int i = 0; i < 24; i++) begin
      r_we    = 1'($urandom);
      r_byt   = 1'($urandom);
      r_addr  = 22'($urandom);
      r_wdata = 16'($urandom);
      r_rdata = 16'($urandom);
      r_hold  = (i != 23) && ($urandom_range(0, 1) == 1);
      run_op(r_we, r_byt, r_addr, r_wdata, r_rdata,
             expect_wdata(r_byt, r_wdata), r_rdata, r_hold);
    end

    // Reset in cycle N+2 of a read: strobe drops at once, no ack, rdata cleared
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_byte  = 1'b0;
    bus.cpu_addr  = 22'h001000;
    bus.ram_rdata = 16'hDEAD;
    tick;
    bus.cpu_req = 1'b0;
    tick;
    chk("abort_pre_read", 32'(bus.ram_read), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    model_rdata = 16'h0000;
    chk("abort_ram_read",  32'(bus.ram_read),  32'd0);
    chk("abort_cpu_busy",  32'(bus.cpu_busy),  32'd0);
    chk("abort_cpu_rdata", 32'(bus.cpu_rdata), 32'(model_rdata));
    chk("abort_state",     32'(dut.state_q),   32'(ST_WAIT_INIT));
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("abort_no_ack",    32'(bus.cpu_ack),   32'd0);
      chk("abort_no_read",   32'(bus.ram_read),  32'd0);
      chk("abort_rdata_low", 32'(bus.cpu_rdata), 32'(model_rdata));
    end

    // Normal service resumes after the reset
    run_op(1'b0, 1'b0, 22'h000200, 16'h0000, 16'h6B6B, 16'h0000, 16'h6B6B, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule
